// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, optional 2-entry skid buffer,
// freeze/flush control and saturating bubble/flush counters. Latency 1 cycle.
module pipeline_stage_reg #(
   parameter int DATA_W         = 160,
   parameter bit SKID_EN        = 1'b1,
   parameter bit ZERO_ON_BUBBLE = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              freeze,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_d;
   logic              main_v;
   logic              accept;
   logic              drain;

   assign main_v    = (state != EMPTY);
   assign out_valid = main_v && !freeze;
   assign out_data  = (ZERO_ON_BUBBLE && !main_v) ? '0 : main_d;
   assign occupancy = 2'(state);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // With the skid entry, ready depends only on local state, breaking the ready chain.
   always_comb begin
      in_ready = 1'b0;
      if (SKID_EN) in_ready = !freeze && (state != SKID);
      else         in_ready = !freeze && (!main_v || out_ready);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= EMPTY;
         main_d <= '0;
         skid_d <= '0;
      end else if (flush) begin
         state  <= EMPTY;
         main_d <= '0;
         skid_d <= '0;
      end else if (!freeze) begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state  <= FULL;
                  main_d <= in_data;
               end
            end
            FULL: begin
               if (accept && drain) begin
                  main_d <= in_data;
               end else if (accept) begin
                  state  <= SKID;
                  skid_d <= in_data;
               end else if (drain) begin
                  state <= EMPTY;
               end
            end
            SKID: begin
               if (drain) begin
                  state  <= FULL;
                  main_d <= skid_d;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Counters saturate at all-ones and are cleared only by reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (!freeze && out_ready && !main_v && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: skid and non-skid instances checked against a queue-based model.
// Latency: design under test is 1 cycle; checks sample at negedge after inputs settle.
// Backpressure: out_ready driven directed and random; in_ready compared every checked cycle.
module tb_pipeline_stage_reg;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          freeze, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0]    occupancy1, occupancy0;
    logic [CW-1:0] bubble_cnt1, flush_cnt1, bubble_cnt0, flush_cnt0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    int bub1, fl1, bub0, fl0;

    always #5 CLK = ~CLK;

    pipeline_stage_reg #(.DATA_W(DW), .SKID_EN(1'b1), .ZERO_ON_BUBBLE(1'b1), .CNT_W(CW)) dut1 (
        .CLK(CLK), .nRST(nRST), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occupancy1), .bubble_cnt(bubble_cnt1), .flush_cnt(flush_cnt1));

    pipeline_stage_reg #(.DATA_W(DW), .SKID_EN(1'b0), .ZERO_ON_BUBBLE(1'b1), .CNT_W(CW)) dut0 (
        .CLK(CLK), .nRST(nRST), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occupancy0), .bubble_cnt(bubble_cnt0), .flush_cnt(flush_cnt0));

    // Expected {in_ready, out_valid, occupancy, out_data, bubble_cnt, flush_cnt} for the current cycle.
    function automatic logic [43:0] exp1();
        logic [DW-1:0] d;
        d = (q1.size() > 0) ? q1[0] : '0;
        return {!freeze && (q1.size() < 2), (q1.size() > 0) && !freeze, 2'(q1.size()), d, 4'(bub1), 4'(fl1)};
    endfunction

    function automatic logic [43:0] exp0();
        logic [DW-1:0] d;
        d = (q0.size() > 0) ? q0[0] : '0;
        return {!freeze && ((q0.size() == 0) || out_ready), (q0.size() > 0) && !freeze, 2'(q0.size()), d,
                4'(bub0), 4'(fl0)};
    endfunction

    function automatic logic [43:0] obs1();
        return {in_ready1, out_valid1, occupancy1, out_data1, bubble_cnt1, flush_cnt1};
    endfunction

    function automatic logic [43:0] obs0();
        return {in_ready0, out_valid0, occupancy0, out_data0, bubble_cnt0, flush_cnt0};
    endfunction

    task automatic model_edge();
        logic r1, r0;
        if (!freeze && out_ready && q1.size() == 0 && bub1 < CMAX) bub1++;
        if (!freeze && out_ready && q0.size() == 0 && bub0 < CMAX) bub0++;
        if (flush && fl1 < CMAX) fl1++;
        if (flush && fl0 < CMAX) fl0++;
        if (flush) begin
            q1.delete();
            q0.delete();
        end else if (!freeze) begin
            r1 = (q1.size() < 2);
            r0 = (q0.size() == 0) || out_ready;
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (in_valid && r1) q1.push_back(in_data);
            if (in_valid && r0) q0.push_back(in_data);
        end
    endtask

    task automatic model_clear();
        q1.delete();
        q0.delete();
        bub1 = 0; fl1 = 0; bub0 = 0; fl0 = 0;
    endtask

    task automatic set_in(input logic fr, input logic fl, input logic iv, input logic [DW-1:0] d,
                          input logic ordy);
        freeze = fr; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, '0, 0);
        model_clear();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({out_valid1, out_data1, occupancy1, bubble_cnt1, flush_cnt1} !== '0) begin
            errors++;
            $display("FAIL reset_init got v=%b d=%h occ=%0d b=%0d f=%0d want zeros",
                     out_valid1, out_data1, occupancy1, bubble_cnt1, flush_cnt1);
        end
        nRST = 1'b1;
        #1;
        checks++;
        if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b/%b want 1/1", in_ready1, in_ready0);
        end
        @(posedge CLK);
        #1;
        for (int k = 1; k <= 3; k++) begin
            set_in(0, 0, 1, DW'(k), 1);
            settle();
            step();
        end
        checks++;
        if (occupancy1 !== 2'd1 || bubble_cnt1 !== 4'd1) begin
            errors++;
            $display("FAIL midstream_pre_reset got occ=%0d b=%0d want 1 1", occupancy1, bubble_cnt1);
        end
        nRST = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({out_valid1, out_data1, occupancy1, bubble_cnt1, flush_cnt1,
             out_valid0, out_data0, occupancy0, bubble_cnt0, flush_cnt0} !== '0) begin
            errors++;
            $display("FAIL reset_midstream got v=%b d=%h occ=%0d b=%0d | v0=%b d0=%h occ0=%0d want zeros",
                     out_valid1, out_data1, occupancy1, bubble_cnt1, out_valid0, out_data0, occupancy0);
        end
        set_in(0, 0, 0, '0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_midstream_ready got %b want 1", in_ready1);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 8; k++) begin
            set_in(0, 0, 1, DW'(k), 1);
            settle();
            if (k > 1) begin
                checks++;
                if (out_valid1 !== 1'b1 || out_data1 !== DW'(k - 1) ||
                    out_valid0 !== 1'b1 || out_data0 !== DW'(k - 1)) begin
                    errors++;
                    $display("FAIL stream_%0d got %b:%h / %b:%h want 1:%h", k, out_valid1, out_data1,
                             out_valid0, out_data0, DW'(k - 1));
                end
            end
            step();
        end
        checks++;
        if (bubble_cnt1 !== 4'd1 || bubble_cnt0 !== 4'd1) begin
            errors++;
            $display("FAIL stream_bubble got %0d/%0d want 1", bubble_cnt1, bubble_cnt0);
        end
        set_in(0, 0, 0, '0, 1);
        settle();
        checks++;
        if (out_data1 !== DW'(8)) begin
            errors++;
            $display("FAIL stream_last got %h want 8", out_data1);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b;
        a = DW'($urandom);
        b = DW'($urandom);
        set_in(0, 0, 1, a, 0); settle(); step();
        set_in(0, 0, 1, b, 0); settle(); step();
        set_in(0, 0, 0, '0, 0);
        settle();
        checks++;
        if (occupancy1 !== 2'd2 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got occ=%0d rdy=%b want 2 0", occupancy1, in_ready1);
        end
        step();
        set_in(0, 0, 0, '0, 1);
        settle();
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== a) begin
            errors++;
            $display("FAIL bp_first got %b:%h want 1:%h", out_valid1, out_data1, a);
        end
        step();
        settle();
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== b) begin
            errors++;
            $display("FAIL bp_second got %b:%h want 1:%h", out_valid1, out_data1, b);
        end
        step();
        settle();
        checks++;
        if (out_valid1 !== 1'b0 || out_data1 !== '0) begin
            errors++;
            $display("FAIL bp_empty got %b:%h want 0:0", out_valid1, out_data1);
        end
        step();
    endtask

    task automatic test_freeze();
        set_in(0, 0, 1, DW'('hAB), 0); settle(); step();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 1, DW'($urandom), 1);
            settle();
            checks++;
            if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin
                errors++;
                $display("FAIL freeze_%0d got v=%b rdy=%b rdy0=%b want 0 0 0", i, out_valid1, in_ready1, in_ready0);
            end
            step();
        end
        set_in(0, 0, 0, '0, 1);
        settle();
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== DW'('hAB)) begin
            errors++;
            $display("FAIL freeze_release got %b:%h want 1:ab", out_valid1, out_data1);
        end
        step();
        settle();
        checks++;
        if (out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL freeze_replay got v=%b want 0", out_valid1);
        end
        step();
    endtask

    task automatic test_flush();
        set_in(0, 0, 1, DW'($urandom), 0); settle(); step();
        set_in(0, 0, 1, DW'($urandom), 0); settle(); step();
        set_in(1, 1, 1, DW'($urandom), 0);
        settle();
        checks++;
        if (occupancy1 !== 2'd2) begin
            errors++;
            $display("FAIL flush_pre got occ=%0d want 2", occupancy1);
        end
        step();
        set_in(0, 0, 0, '0, 0);
        settle();
        checks++;
        if (occupancy1 !== 2'd0 || out_data1 !== '0 || flush_cnt1 !== 4'd1 || occupancy0 !== 2'd0) begin
            errors++;
            $display("FAIL flush_frozen got occ=%0d d=%h f=%0d occ0=%0d want 0 0 1 0",
                     occupancy1, out_data1, flush_cnt1, occupancy0);
        end
        step();
        set_in(0, 1, 1, DW'($urandom), 0);
        settle();
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready got %b want 1", in_ready1);
        end
        step();
        set_in(0, 0, 0, '0, 0);
        settle();
        checks++;
        if (occupancy1 !== 2'd0 || flush_cnt1 !== 4'd2) begin
            errors++;
            $display("FAIL flush_drop got occ=%0d f=%0d want 0 2", occupancy1, flush_cnt1);
        end
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            set_in(0, 0, 0, '0, 1);
            settle();
            step();
        end
        checks++;
        if (bubble_cnt1 !== 4'd15 || bubble_cnt0 !== 4'd15) begin
            errors++;
            $display("FAIL bubble_saturate got %0d/%0d want 15", bubble_cnt1, bubble_cnt0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                set_in(0, 0, 0, '0, 0);
                nRST = 1'b0;
                #1;
                model_clear();
                @(negedge CLK);
                nRST = 1'b1;
                @(posedge CLK);
                #1;
            end
            set_in($urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0, 1'($urandom),
                   DW'($urandom), $urandom_range(0, 3) != 0);
            settle();
            checks++;
            if (obs1() !== exp1()) begin
                errors++;
                $display("FAIL rand_skid_%0d got %h want %h", i, obs1(), exp1());
            end
            checks++;
            if (obs0() !== exp0()) begin
                errors++;
                $display("FAIL rand_noskid_%0d got %h want %h", i, obs0(), exp0());
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_freeze();
        test_flush();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
